// File: rtl/native_bus_pkg.sv
// native_bus_pkg: shared types and constants for the native parallel bus initiator and range checker
package native_bus_pkg;
    localparam int WAIT_W = 4;
    localparam int RANGE_W = 32;
    localparam logic [RANGE_W-1:0] DEFAULT_PARK_ADDR = '1;
    typedef enum logic [1:0] {IDLE, ACCESS, VERIFY, RESP} state_t;
    typedef struct packed {
        logic [RANGE_W-1:0] base;
        logic [RANGE_W-1:0] end_excl;
    } addr_range_t;
    function automatic addr_range_t make_range(input int unsigned base, input int unsigned end_excl);
        return '{base: RANGE_W'(base), end_excl: RANGE_W'(end_excl)};
    endfunction
endpackage

// File: rtl/native_bus_initiator_if.sv
// native_bus_initiator_if: command/response handshakes plus the native bus (r_wn/addr/wdata/rdata)
// master: initiator view (drives cmd_ready, rsp_*, busy, r_wn, addr, wdata)
// slave:  host/endpoint view (drives cmd_*, rsp_ready, rdata)
interface native_bus_initiator_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_r_wn;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic                  r_wn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    modport master (
        input  cmd_valid, cmd_r_wn, cmd_addr, cmd_wdata, rsp_ready, rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, r_wn, addr, wdata
    );
    modport slave (
        output cmd_valid, cmd_r_wn, cmd_addr, cmd_wdata, rsp_ready, rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, r_wn, addr, wdata
    );
endinterface

// File: rtl/native_bus_range_chk.sv
// native_bus_range_chk: combinational check that addr falls in either of two half-open windows
// Ports: addr (in), range0/range1 (in, {base, end_excl}), in_range (out)
module native_bus_range_chk
    import native_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  addr_range_t           range0,
    input  addr_range_t           range1,
    output logic                  in_range
);
    logic [RANGE_W-1:0] a;
    assign a = RANGE_W'(addr);
    assign in_range = (a >= range0.base && a < range0.end_excl) || (a >= range1.base && a < range1.end_excl);
endmodule

// File: rtl/native_bus_initiator.sv
// native_bus_initiator: single-outstanding host for the native bus; range-checks commands, holds the bus WAIT_CYCLES+1 cycles, returns one response each
// Ports: clk, rst (async, active-high), bus (native_bus_initiator_if.master: cmd_*, rsp_*, busy, r_wn/addr/wdata out, rdata in)
// Optional: define NATIVE_BUS_WR_VERIFY_EN to read back every in-range write and flag mismatches in rsp_err
module native_bus_initiator
    import native_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int RANGE0_BASE = 0,
    parameter int RANGE0_END = 8,
    parameter int RANGE1_BASE = 32,
    parameter int RANGE1_END = 160,
    parameter logic [ADDR_WIDTH-1:0] PARK_ADDR = ADDR_WIDTH'(DEFAULT_PARK_ADDR)
) (
    input logic clk,
    input logic rst,
    native_bus_initiator_if.master bus
);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
    localparam addr_range_t RANGE0 = make_range(RANGE0_BASE, RANGE0_END);
    localparam addr_range_t RANGE1 = make_range(RANGE1_BASE, RANGE1_END);
    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  r_wn_q, r_wn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  in_range;

    native_bus_range_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_range_chk (
        .addr    (bus.cmd_addr),
        .range0  (RANGE0),
        .range1  (RANGE1),
        .in_range(in_range)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d = rsp_err_q;
        r_wn_d = r_wn_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (bus.cmd_valid && cmd_ready_q) begin
                rsp_rdata_d = '0;
                if (in_range) begin
                    state_d = ACCESS;
                    cnt_d = WAIT_INIT;
                    r_wn_d = bus.cmd_r_wn;
                    addr_d = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                end else begin
                    state_d = RESP;
                    rsp_err_d = 1'b1;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rsp_rdata_d = r_wn_q ? bus.rdata : '0;
                    r_wn_d = 1'b1;
                    addr_d = PARK_ADDR;
                    wdata_d = '0;
`ifdef NATIVE_BUS_WR_VERIFY_EN
                    if (!r_wn_q) begin
                        // keep addr and the written data so the read-back can be compared
                        state_d = VERIFY;
                        cnt_d = WAIT_INIT;
                        addr_d = addr_q;
                        wdata_d = wdata_q;
                    end
`endif
                end
            end
`ifdef NATIVE_BUS_WR_VERIFY_EN
            VERIFY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rsp_err_d = bus.rdata != wdata_q;
                    addr_d = PARK_ADDR;
                    wdata_d = '0;
                end
            end
`endif
            RESP: if (bus.rsp_ready) begin
                state_d = IDLE;
                rsp_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // handshake flags follow the state being entered so they stay registered
        cmd_ready_d = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q <= 1'b0;
            r_wn_q <= 1'b1;
            addr_q <= PARK_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q <= rsp_err_d;
            r_wn_q <= r_wn_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err = rsp_err_q;
    assign bus.busy = state_q != IDLE;
    assign bus.r_wn = r_wn_q;
    assign bus.addr = addr_q;
    assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_native_bus_initiator.sv
// tb_native_bus_initiator: scoreboard bench for native_bus_initiator with an endpoint memory and a reference model
module tb_native_bus_initiator;
    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;
`ifdef NATIVE_BUS_WR_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
    localparam int WR_EXTRA = 2;
`else
    localparam bit VERIFY_EN = 1'b0;
    localparam int WR_EXTRA = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int passed = 0;
    bit rand_rdy = 1'b0;
    exp_t exp_q[$];
    logic [7:0] ep_mem [256] = '{default: '0};
    logic [7:0] ref_mem [256] = '{default: '0};

    native_bus_initiator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    native_bus_initiator dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic bit in_win(input logic [7:0] a);
        return a < 8'd8 || (a >= 8'd32 && a < 8'd160);
    endfunction

    // one endpoint bit is stuck at 0 when the write-verify build is exercised
    function automatic logic [7:0] stuck(input logic [7:0] a);
        return (VERIFY_EN && a == 8'h50) ? 8'h01 : 8'h00;
    endfunction

    always @(posedge clk) if (!bus.r_wn && in_win(bus.addr)) ep_mem[bus.addr] <= bus.wdata & ~stuck(bus.addr);
    assign bus.rdata = (bus.r_wn && in_win(bus.addr)) ? ep_mem[bus.addr] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    task automatic model(input bit r, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        if (!in_win(a)) e = '{8'h00, 1'b1};
        else if (r) e = '{ref_mem[a], 1'b0};
        else begin
            ref_mem[a] = d & ~stuck(a);
            e = '{8'h00, VERIFY_EN && ((d & stuck(a)) != 8'h00)};
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%0h, want no response", bus.rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", bus.rsp_err, e.err);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.rsp_ready = $urandom_range(0, 2) != 0;
    end

    task automatic set_rdy(input logic v);
        @(posedge clk);
        #1;
        bus.rsp_ready = v;
    endtask

    // returns at the falling edge of the first cycle after acceptance
    task automatic send(input bit r, input logic [7:0] a, input logic [7:0] d, input bit push);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_r_wn = r;
        bus.cmd_addr = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            total++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 for 100 cycles, want 1");
        end else if (push) model(r, a, d);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n == limit) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending responses, want 0", exp_q.size());
        end
    endtask

    task automatic bus_is(input string tag, input logic r, input logic [7:0] a);
        chk({tag, "_r_wn"}, bus.r_wn, r);
        chk({tag, "_addr"}, bus.addr, a);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2000000, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bnd [6] = '{8'h07, 8'h08, 8'h1F, 8'h20, 8'h9F, 8'hA0};
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_r_wn = 1'b1;
        bus.cmd_addr = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", bus.busy, 0);
        bus_is("rst", 1'b1, 8'hFF);
        chk("rst_wdata", bus.wdata, 0);
        rst = 1'b0;
        set_rdy(1'b1);
        send(1'b0, 8'h03, 8'h5A, 1'b1);
        bus_is("wr_c1", 1'b0, 8'h03);
        chk("wr_c1_wdata", bus.wdata, 8'h5A);
        @(negedge clk);
        bus_is("wr_c2", 1'b0, 8'h03);
        chk("wr_c2_wdata", bus.wdata, 8'h5A);
        repeat (WR_EXTRA) begin
            @(negedge clk);
            bus_is("wr_vfy", 1'b1, 8'h03);
        end
        @(negedge clk);
        bus_is("wr_park", 1'b1, 8'hFF);
        chk("wr_rsp_valid", bus.rsp_valid, 1);
        wait_drain(50);
        send(1'b1, 8'h03, 8'h00, 1'b1);
        bus_is("rd_c1", 1'b1, 8'h03);
        @(negedge clk);
        bus_is("rd_c2", 1'b1, 8'h03);
        @(negedge clk);
        bus_is("rd_park", 1'b1, 8'hFF);
        chk("rd_rsp_valid", bus.rsp_valid, 1);
        wait_drain(50);
        send(1'b0, 8'h40, 8'hC3, 1'b1);
        wait_drain(50);
        send(1'b1, 8'h40, 8'h00, 1'b1);
        wait_drain(50);
        foreach (bnd[i]) begin
            send(1'b1, bnd[i], 8'h00, 1'b1);
            chk("bnd_rsp_valid_c1", bus.rsp_valid, !in_win(bnd[i]));
            chk("bnd_addr_c1", bus.addr, in_win(bnd[i]) ? bnd[i] : 8'hFF);
            wait_drain(50);
        end
        // response back-pressure with a second command already waiting
        set_rdy(1'b0);
        send(1'b1, 8'h40, 8'h00, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            total++;
            $display("FAIL stall_rsp_timeout: got rsp_valid=0, want 1");
        end
        bus.cmd_r_wn = 1'b0;
        bus.cmd_addr = 8'h41;
        bus.cmd_wdata = 8'h77;
        bus.cmd_valid = 1'b1;
        model(1'b0, 8'h41, 8'h77);
        repeat (5) begin
            @(negedge clk);
            chk("stall_rsp_valid", bus.rsp_valid, 1);
            chk("stall_rsp_rdata", bus.rsp_rdata, 8'hC3);
            chk("stall_cmd_ready", bus.cmd_ready, 0);
            chk("stall_busy", bus.busy, 1);
            chk("stall_addr", bus.addr, 8'hFF);
        end
        set_rdy(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("hs_cmd_ready", bus.cmd_ready, 1);
        chk("hs_busy", bus.busy, 0);
        chk("hs_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        bus_is("second_c1", 1'b0, 8'h41);
        chk("second_busy", bus.busy, 1);
        bus.cmd_valid = 1'b0;
        wait_drain(50);
        // reset during the second ACCESS cycle of a write; the endpoint already saw one write cycle
        send(1'b0, 8'h06, 8'h99, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        bus_is("midrst", 1'b1, 8'hFF);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        ref_mem[8'h06] = 8'h99;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 8'h05, 8'h00, 1'b1);
        bus_is("postrst_c1", 1'b1, 8'h05);
        wait_drain(50);
`ifdef NATIVE_BUS_WR_VERIFY_EN
        send(1'b0, 8'h50, 8'h11, 1'b1);
        bus_is("vfy_c1", 1'b0, 8'h50);
        @(negedge clk);
        bus_is("vfy_c2", 1'b0, 8'h50);
        @(negedge clk);
        bus_is("vfy_c3", 1'b1, 8'h50);
        @(negedge clk);
        bus_is("vfy_c4", 1'b1, 8'h50);
        chk("vfy_c4_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        chk("vfy_c5_rsp_valid", bus.rsp_valid, 1);
        wait_drain(50);
        send(1'b0, 8'h51, 8'h11, 1'b1);
        wait_drain(50);
`endif
        rand_rdy = 1'b1;
        repeat (150) begin
            logic [7:0] a;
            case ($urandom_range(0, 3))
                0: a = 8'($urandom_range(0, 7));
                1: a = 8'($urandom_range(32, 159));
                2: a = 8'($urandom_range(0, 255));
                default: a = 8'($urandom_range(8'h40, 8'h47));
            endcase
            send(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), 1'b1);
        end
        wait_drain(500);
        rand_rdy = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/native_bus_initiator.md
Name: native_bus_initiator

Overview:
- Synthesizable initiator (host side) for the native parallel bus (r_wn/addr/wdata/rdata) served by bus_endpoint instances.
- Accepts single read/write commands on a valid/ready interface, range-checks the address, then drives the bus for a fixed number of cycles.
- Captures the OR-combined endpoint rdata and returns one response per command on a valid/ready interface.
- Replaces the behavioural host in system-level integration.

Parameters:
- ADDR_WIDTH, 8, bus address width.
- DATA_WIDTH, 8, bus data width.
- WAIT_CYCLES, 1, extra cycles the bus is held beyond the first; valid range 0..15.
- RANGE0_BASE, 0, first valid window start (inclusive).
- RANGE0_END, 8, first valid window end (exclusive).
- RANGE1_BASE, 32, second valid window start (inclusive).
- RANGE1_END, 160, second valid window end (exclusive).
- PARK_ADDR, all-ones, address driven while idle; must lie outside both windows.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_r_wn  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range (or write-verify mismatch).
- busy  out  1  high whenever state is not IDLE.
- r_wn  out  1  bus read/not-write.
- addr  out  ADDR_WIDTH  bus address.
- wdata  out  DATA_WIDTH  bus write data.
- rdata  in  DATA_WIDTH  OR of all endpoint read data.

Behaviour:
- All bus outputs are registered; the bus is never driven combinationally from cmd_*.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, r_wn=1, addr=PARK_ADDR, wdata=0, state=IDLE. Reset takes effect immediately, including mid-transaction; any in-flight command is dropped with no response.
- States: IDLE, ACCESS, (VERIFY), RESP.
- IDLE:
  - cmd_ready=1; bus parked (r_wn=1, addr=PARK_ADDR, wdata=0).
  - On accept, the address is in range iff RANGE0_BASE<=a<RANGE0_END or RANGE1_BASE<=a<RANGE1_END, compared unsigned at ADDR_WIDTH.
  - In range: register r_wn/addr/wdata onto the bus, load the wait counter with WAIT_CYCLES, go to ACCESS.
  - Out of range: bus stays parked; rsp_err=1, rsp_rdata=0; go to RESP.
- ACCESS:
  - Bus held constant for WAIT_CYCLES+1 cycles; counter decrements each cycle.
  - In the cycle the counter is 0: for a read, latch rdata into rsp_rdata. Next state is RESP, or VERIFY for writes when the feature is enabled.
  - The bus parks on the edge leaving ACCESS.
- RESP:
  - rsp_valid=1; rsp_* stable until rsp_ready.
  - On handshake: rsp_valid=0, rsp_err=0, return to IDLE.
  - cmd_ready=0 throughout, so at most one command is outstanding.
- Latency, WAIT_CYCLES=1, command accepted at edge 0:
  - Bus active cycles 1-2.
  - rsp_valid from cycle 3.
  - Next command acceptable the cycle after the response handshake.
  - Out-of-range: rsp_valid from cycle 1.
- cmd_valid while not ready is ignored. The initiator never depends on cmd_valid staying high.

Optional Feature:
- Macro: NATIVE_BUS_WR_VERIFY_EN.
- Defined: after the ACCESS of an in-range write, enter VERIFY.
  - Bus drives r_wn=1 with the same addr for WAIT_CYCLES+1 cycles.
  - On the last cycle, compare rdata with the written data; rsp_err=1 on mismatch. rsp_rdata stays 0.
  - Write latency grows by WAIT_CYCLES+1 cycles.
- Undefined: the VERIFY state and its logic are absent; writes always return rsp_err=0 when in range.

Decomposition:
- Package native_bus_pkg holds:
  - state enum typedef (IDLE, ACCESS, VERIFY, RESP);
  - addr_range_t struct {base, end_excl};
  - default PARK_ADDR constant;
  - WAIT counter width localparam (4).
- Sub-module native_bus_range_chk: combinational; takes addr and two ranges, outputs in_range. It is reusable by endpoints and the bench.

Test Plan:
- Write cmd addr=0x03 wdata=0x5A, WAIT_CYCLES=1, accepted cycle 0 -> r_wn=0, addr=0x03, wdata=0x5A on cycles 1-2; bus parked (0xFF) cycle 3; rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read addr=0x03 after the write -> r_wn=1, addr=0x03 cycles 1-2; rsp_rdata=0x5A, rsp_err=0. Write 0xC3 to 0x40 then read 0x40 -> rsp_rdata=0xC3.
- Boundary addresses 0x07, 0x08, 0x1F, 0x20, 0x9F, 0xA0 -> rsp_err = 0,1,1,0,0,1. Erroring commands produce no bus activity and rsp_valid in cycle 1.
- Hold rsp_ready=0 for 5 cycles with cmd_valid held high -> rsp_valid/rsp_rdata stable, cmd_ready=0, busy=1, bus parked. The second command is accepted only the cycle after the handshake.
- Assert rst during the second ACCESS cycle of a write -> same cycle: r_wn=1, addr=0xFF, busy=0, no response. After release, a read of 0x05 completes normally.
- With NATIVE_BUS_WR_VERIFY_EN, write 0x11 to an endpoint bit forced stuck-at-0 -> VERIFY read on cycles 3-4, rsp_valid cycle 5 with rsp_err=1. A healthy address gives rsp_err=0.
